// File: rtl/eth_hdr_serializer.sv
// Ethernet header serializer: 14-byte header, then payload pass-through on 8-bit AXIS.
// Optional zero-padding to MIN_FRAME_LEN when ETH_HDR_PAD_EN is defined.
module eth_hdr_serializer #(
  parameter int MIN_FRAME_LEN = 60
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s_eth_hdr_valid,
  output logic        s_eth_hdr_ready,
  input  logic [47:0] s_eth_dest_mac,
  input  logic [47:0] s_eth_src_mac,
  input  logic [15:0] s_eth_type,
  input  logic [7:0]  s_eth_payload_axis_tdata,
  input  logic        s_eth_payload_axis_tvalid,
  output logic        s_eth_payload_axis_tready,
  input  logic        s_eth_payload_axis_tlast,
  input  logic        s_eth_payload_axis_tuser,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic        m_axis_tuser,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HEADER,
    S_PAYLOAD,
    S_PAD
  } state_t;

  if (MIN_FRAME_LEN < 15 || MIN_FRAME_LEN > 63) begin : g_bad_min
    $error("MIN_FRAME_LEN out of range 15..63");
  end

  state_t       state_q, state_d;
  logic [111:0] hdr_q, hdr_d;
  logic [3:0]   byte_idx_q, byte_idx_d;
  logic [5:0]   frame_cnt_q, frame_cnt_d;
  logic [5:0]   cnt_inc;
  logic [3:0]   sel;

`ifdef ETH_HDR_PAD_EN
  localparam logic [5:0] MinLen = 6'(MIN_FRAME_LEN);
  logic tuser_sv_q, tuser_sv_d;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      hdr_q       <= '0;
      byte_idx_q  <= '0;
      frame_cnt_q <= '0;
`ifdef ETH_HDR_PAD_EN
      tuser_sv_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      hdr_q       <= hdr_d;
      byte_idx_q  <= byte_idx_d;
      frame_cnt_q <= frame_cnt_d;
`ifdef ETH_HDR_PAD_EN
      tuser_sv_q  <= tuser_sv_d;
`endif
    end
  end

  // Byte 0 of the header is the MSB of the destination MAC
  assign sel     = 4'd13 - byte_idx_q;
  assign cnt_inc = (frame_cnt_q == 6'h3f) ? frame_cnt_q : frame_cnt_q + 6'd1;
  assign busy    = (state_q != S_IDLE);

  always_comb begin
    state_d                   = state_q;
    hdr_d                     = hdr_q;
    byte_idx_d                = byte_idx_q;
    frame_cnt_d               = frame_cnt_q;
`ifdef ETH_HDR_PAD_EN
    tuser_sv_d                = tuser_sv_q;
`endif
    s_eth_hdr_ready           = 1'b0;
    s_eth_payload_axis_tready = 1'b0;
    m_axis_tdata              = 8'h00;
    m_axis_tvalid             = 1'b0;
    m_axis_tlast              = 1'b0;
    m_axis_tuser              = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        s_eth_hdr_ready = ~rst;
        if (s_eth_hdr_valid) begin
          hdr_d       = {s_eth_dest_mac, s_eth_src_mac, s_eth_type};
          byte_idx_d  = 4'd0;
          frame_cnt_d = 6'd0;
          state_d     = S_HEADER;
        end
      end
      S_HEADER: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = hdr_q[{sel, 3'b000} +: 8];
        if (m_axis_tready) begin
          byte_idx_d  = byte_idx_q + 4'd1;
          frame_cnt_d = cnt_inc;
          if (byte_idx_q == 4'd13) begin
            state_d = S_PAYLOAD;
          end
        end
      end
      S_PAYLOAD: begin
        m_axis_tdata              = s_eth_payload_axis_tdata;
        m_axis_tvalid             = s_eth_payload_axis_tvalid;
        m_axis_tlast              = s_eth_payload_axis_tlast;
        m_axis_tuser              = s_eth_payload_axis_tuser;
        s_eth_payload_axis_tready = m_axis_tready;
        if (s_eth_payload_axis_tvalid && m_axis_tready) begin
          frame_cnt_d = cnt_inc;
          if (s_eth_payload_axis_tlast) begin
`ifdef ETH_HDR_PAD_EN
            if (cnt_inc < MinLen) begin
              m_axis_tlast = 1'b0;
              m_axis_tuser = 1'b0;
              tuser_sv_d   = s_eth_payload_axis_tuser;
              state_d      = S_PAD;
            end else begin
              state_d = S_IDLE;
            end
`else
            state_d = S_IDLE;
`endif
          end
        end
      end
`ifdef ETH_HDR_PAD_EN
      S_PAD: begin
        m_axis_tvalid = 1'b1;
        m_axis_tlast  = (cnt_inc >= MinLen);
        m_axis_tuser  = (cnt_inc >= MinLen) & tuser_sv_q;
        if (m_axis_tready) begin
          frame_cnt_d = cnt_inc;
          if (cnt_inc >= MinLen) begin
            state_d = S_IDLE;
          end
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_eth_hdr_serializer.sv
// Scoreboard bench for eth_hdr_serializer: directed frames, monitor pops expected beats.
// Covers full frame, backpressure, short frame, back-to-back, payload stall, mid-header reset.
module tb_eth_hdr_serializer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_eth_hdr_valid = 1'b0;
  logic        s_eth_hdr_ready;
  logic [47:0] s_eth_dest_mac = '0;
  logic [47:0] s_eth_src_mac = '0;
  logic [15:0] s_eth_type = '0;
  logic [7:0]  s_tdata = '0;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic        s_tlast = 1'b0;
  logic        s_tuser = 1'b0;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b1;
  logic        m_axis_tlast;
  logic        m_axis_tuser;
  logic        busy;

  eth_hdr_serializer #(.MIN_FRAME_LEN(60)) dut (
    .clk                       (clk),
    .rst                       (rst),
    .s_eth_hdr_valid           (s_eth_hdr_valid),
    .s_eth_hdr_ready           (s_eth_hdr_ready),
    .s_eth_dest_mac            (s_eth_dest_mac),
    .s_eth_src_mac             (s_eth_src_mac),
    .s_eth_type                (s_eth_type),
    .s_eth_payload_axis_tdata  (s_tdata),
    .s_eth_payload_axis_tvalid (s_tvalid),
    .s_eth_payload_axis_tready (s_tready),
    .s_eth_payload_axis_tlast  (s_tlast),
    .s_eth_payload_axis_tuser  (s_tuser),
    .m_axis_tdata              (m_axis_tdata),
    .m_axis_tvalid             (m_axis_tvalid),
    .m_axis_tready             (m_axis_tready),
    .m_axis_tlast              (m_axis_tlast),
    .m_axis_tuser              (m_axis_tuser),
    .busy                      (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] d;
    logic       l;
    logic       u;
  } beat_t;

  beat_t exp_q[$];
  int    checks = 0;
  int    passes = 0;
  int    cyc = 0;
  int    gap = 0;
  int    last_cyc = 0;
  int    excl_viol = 0;
  int    stab_viol = 0;
  logic  tog = 1'b0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %0h required %0h", name, act, req);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (tog) m_axis_tready = ~m_axis_tready;
    else m_axis_tready = 1'b1;
  end

  // Monitor: pops one expected beat per accepted output beat
  initial begin
    logic  prev_stall;
    logic  after_last;
    beat_t pv;
    beat_t e;
    prev_stall = 1'b0;
    after_last = 1'b0;
    pv = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
        after_last = 1'b0;
      end else begin
        if (busy && s_eth_hdr_ready) excl_viol++;
        if (prev_stall &&
            (!m_axis_tvalid ||
             pv != {m_axis_tdata, m_axis_tlast, m_axis_tuser}))
          stab_viol++;
        prev_stall = m_axis_tvalid && !m_axis_tready;
        pv = {m_axis_tdata, m_axis_tlast, m_axis_tuser};
        if (m_axis_tvalid && m_axis_tready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_beat", {m_axis_tdata, m_axis_tlast, m_axis_tuser}, 32'hffff_ffff);
          end else begin
            e = exp_q.pop_front();
            chk("beat", {22'd0, m_axis_tdata, m_axis_tlast, m_axis_tuser},
                {22'd0, e.d, e.l, e.u});
          end
          if (after_last) gap = cyc - last_cyc;
          after_last = m_axis_tlast;
          if (m_axis_tlast) last_cyc = cyc;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push_hdr(input logic [47:0] d, input logic [47:0] s,
                          input logic [15:0] t);
    logic [111:0] h;
    h = {d, s, t};
    for (int i = 0; i < 14; i++) exp_q.push_back('{h[111-8*i -: 8], 1'b0, 1'b0});
  endtask

  task automatic push_frame(input logic [47:0] d, input logic [47:0] s,
                            input logic [15:0] t, input logic [7:0] p[$],
                            input logic tu);
    int   n;
    logic pad;
    n = p.size();
`ifdef ETH_HDR_PAD_EN
    pad = (14 + n) < 60;
`else
    pad = 1'b0;
`endif
    push_hdr(d, s, t);
    for (int i = 0; i < n; i++) begin
      logic lst;
      lst = (i == n - 1) && !pad;
      exp_q.push_back('{p[i], lst, lst && tu});
    end
    if (pad)
      for (int j = 14 + n; j < 60; j++)
        exp_q.push_back('{8'h00, j == 59, (j == 59) && tu});
  endtask

  task automatic wait_accept(input logic is_hdr, input string name);
    int t;
    t = 0;
    forever begin
      @(negedge clk);
      if (is_hdr ? s_eth_hdr_ready : s_tready) break;
      t++;
      if (t > 1000) begin
        chk({name, "_timeout"}, 32'd1, 32'd0);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_hdr(input logic [47:0] d, input logic [47:0] s,
                          input logic [15:0] t, input logic keep);
    s_eth_dest_mac  = d;
    s_eth_src_mac   = s;
    s_eth_type      = t;
    s_eth_hdr_valid = 1'b1;
    wait_accept(1'b1, "hdr");
    if (!keep) s_eth_hdr_valid = 1'b0;
  endtask

  task automatic send_payload(input logic [7:0] p[$], input logic tu,
                              input int stall_after);
    for (int i = 0; i < p.size(); i++) begin
      s_tdata  = p[i];
      s_tlast  = (i == p.size() - 1);
      s_tuser  = tu && (i == p.size() - 1);
      s_tvalid = 1'b1;
      wait_accept(1'b0, "payload");
      if (i == stall_after) begin
        s_tvalid = 1'b0;
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          chk("stall_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
          @(posedge clk);
          #1;
        end
      end
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    s_tuser  = 1'b0;
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk({name, "_drained"}, exp_q.size(), 32'd0);
  endtask

  localparam logic [47:0] D1 = 48'h02_00_00_00_00_01;
  localparam logic [47:0] S1 = 48'h02_00_00_00_00_02;

  initial begin
    logic [7:0] p46[$];
    logic [7:0] pshort[$];
    logic [7:0] pa[$];
    logic [7:0] pb[$];
    for (int i = 0; i < 46; i++) p46.push_back(8'(i));
    pshort = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    pa = '{8'h11, 8'h22, 8'h33};
    pb = '{8'h44};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
    chk("rst_tlast", {31'd0, m_axis_tlast}, 32'd0);
    chk("rst_tuser", {31'd0, m_axis_tuser}, 32'd0);
    chk("rst_tdata", {24'd0, m_axis_tdata}, 32'd0);
    chk("rst_pl_tready", {31'd0, s_tready}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_hdr_ready", {31'd0, s_eth_hdr_ready}, 32'd0);
    rst = 1'b0;
    #1;
    chk("rel_hdr_ready", {31'd0, s_eth_hdr_ready}, 32'd1);

    push_frame(D1, S1, 16'h0800, p46, 1'b0);
    send_hdr(D1, S1, 16'h0800, 1'b0);
    send_payload(p46, 1'b0, -1);
    drain("full");

    tog = 1'b1;
    push_frame(D1, S1, 16'h0800, p46, 1'b0);
    send_hdr(D1, S1, 16'h0800, 1'b0);
    send_payload(p46, 1'b0, -1);
    drain("bp");
    tog = 1'b0;
    @(posedge clk);
    #1;

    push_frame(D1, S1, 16'h0800, pshort, 1'b1);
    send_hdr(D1, S1, 16'h0800, 1'b0);
    send_payload(pshort, 1'b1, -1);
    drain("short");

    push_frame(D1, S1, 16'h0806, pa, 1'b0);
    push_frame(S1, D1, 16'h86DD, pb, 1'b0);
    send_hdr(D1, S1, 16'h0806, 1'b1);
    s_eth_dest_mac = S1;
    s_eth_src_mac  = D1;
    s_eth_type     = 16'h86DD;
    send_payload(pa, 1'b0, -1);
    send_hdr(S1, D1, 16'h86DD, 1'b0);
    send_payload(pb, 1'b0, -1);
    drain("b2b");
    chk("b2b_gap", gap, 32'd2);

    push_frame(D1, S1, 16'h0800, p46, 1'b0);
    send_hdr(D1, S1, 16'h0800, 1'b0);
    send_payload(p46, 1'b0, 10);
    drain("stall");

    push_hdr(48'h112233445566, 48'h778899AABBCC, 16'h86DD);
    send_hdr(48'h112233445566, 48'h778899AABBCC, 16'h86DD, 1'b0);
    repeat (7) begin
      @(posedge clk);
      #1;
    end
    chk("mid_hdr_byte7", {24'd0, m_axis_tdata}, 32'h88);
    rst = 1'b1;
    #1;
    chk("mid_rst_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_hdr_ready", {31'd0, s_eth_hdr_ready}, 32'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("mid_rel_hdr_ready", {31'd0, s_eth_hdr_ready}, 32'd1);
    push_frame(D1, S1, 16'h0800, p46, 1'b0);
    send_hdr(D1, S1, 16'h0800, 1'b0);
    send_payload(p46, 1'b0, -1);
    drain("after_rst");

    repeat (3) @(posedge clk);
    chk("ready_busy_exclusive", excl_viol, 32'd0);
    chk("stall_stability", stab_viol, 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
